// File: rtl/detection_result_collector.sv
// Detection result collector: filters passing windows into a FWFT FIFO and
// sequences frame flush/done. Optional counters enabled by RESULT_STATS_EN.
module detection_result_collector #(
  parameter int DEPTH      = 16,
  parameter int ROW_BITS   = 10,
  parameter int COL_BITS   = 10,
  parameter int SCALE_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_passfail,
  input  logic [ROW_BITS-1:0]     in_x,
  input  logic [COL_BITS-1:0]     in_y,
  input  logic [SCALE_BITS-1:0]   in_scale,
  output logic                    in_taken,
  input  logic                    frame_end,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROW_BITS-1:0]     out_x,
  output logic [COL_BITS-1:0]     out_y,
  output logic [SCALE_BITS-1:0]   out_scale,
  output logic [$clog2(DEPTH):0]  out_count,
`ifdef RESULT_STATS_EN
  input  logic                    stats_clear,
  output logic [31:0]             stat_windows,
  output logic [31:0]             stat_detections,
`endif
  output logic                    frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = ROW_BITS + COL_BITS + SCALE_BITS;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {COLLECT, FLUSH, DONE} state_t;

  state_t         state_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           full, pop, push;

  assign full      = (count_q == FULL_CNT);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign in_taken  = in_valid & (state_q == COLLECT) & (~in_passfail | ~full | pop);
  assign push      = in_taken & in_passfail;
  assign {out_x, out_y, out_scale} = mem_q[rd_ptr_q];
  assign out_count  = count_q;
  assign frame_done = (state_q == DONE);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_scale};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case (state_q)
        COLLECT: if (frame_end) state_q <= FLUSH;
        // Leaving on the next-cycle occupancy lets frame_done follow the last pop directly
        FLUSH:   if (count_d == '0) state_q <= DONE;
        DONE:    state_q <= COLLECT;
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef RESULT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_windows    <= '0;
      stat_detections <= '0;
    end else if (stats_clear) begin
      stat_windows    <= '0;
      stat_detections <= '0;
    end else begin
      if (in_taken && stat_windows != '1)  stat_windows    <= stat_windows + 1'b1;
      if (push && stat_detections != '1)   stat_detections <= stat_detections + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_detection_result_collector.sv
// Self-checking bench for detection_result_collector: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_detection_result_collector;

  localparam int DEPTH = 16;
  localparam int W     = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_passfail = 1'b0, frame_end = 1'b0, out_ready = 1'b0;
  logic [9:0]  in_x = '0, in_y = '0, out_x, out_y;
  logic [4:0]  in_scale = '0, out_scale;
  logic        in_taken, out_valid, frame_done;
  logic [4:0]  out_count;
`ifdef RESULT_STATS_EN
  logic        stats_clear = 1'b0;
  logic [31:0] stat_windows, stat_detections;
  int unsigned m_win, m_det;
`endif

  int          checks = 0, errors = 0;
  logic [W-1:0] q[$];
  int          ph = 0;          // 0 collecting, 1 flushing, 2 done pulse
  int          fd_seen = 0;
  logic        last_tk = 1'b0;
  logic        rnd_clr = 1'b0;

  detection_result_collector #(.DEPTH(DEPTH), .ROW_BITS(10), .COL_BITS(10), .SCALE_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_passfail(in_passfail),
    .in_x(in_x), .in_y(in_y), .in_scale(in_scale), .in_taken(in_taken),
    .frame_end(frame_end), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .out_count(out_count),
`ifdef RESULT_STATS_EN
    .stats_clear(stats_clear), .stat_windows(stat_windows), .stat_detections(stat_detections),
`endif
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic pf, input logic [W-1:0] t,
                      input logic fe, input logic rdy);
    logic ev, pop, tk;
    @(negedge clk);
    in_valid = v; in_passfail = pf; {in_x, in_y, in_scale} = t;
    frame_end = fe; out_ready = rdy;
`ifdef RESULT_STATS_EN
    stats_clear = rnd_clr;
`endif
    #1;
    ev  = (q.size() != 0);
    pop = ev && rdy;
    tk  = v && (ph == 0) && (!pf || q.size() < DEPTH || pop);
    chk("in_taken", {31'd0, in_taken}, {31'd0, tk});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("out_count", {27'd0, out_count}, q.size());
    chk("frame_done", {31'd0, frame_done}, {31'd0, ph == 2});
    if (ev) chk("head", {7'd0, out_x, out_y, out_scale}, {7'd0, q[0]});
`ifdef RESULT_STATS_EN
    chk("stat_windows", stat_windows, m_win);
    chk("stat_detections", stat_detections, m_det);
    if (rnd_clr) begin m_win = 0; m_det = 0; end
    else begin
      if (tk) m_win++;
      if (tk && pf) m_det++;
    end
`endif
    if (frame_done) fd_seen++;
    if (pop) void'(q.pop_front());
    if (tk && pf) q.push_back(t);
    case (ph)
      0: if (fe) ph = 1;
      1: if (q.size() == 0) ph = 2;
      default: ph = 0;
    endcase
    last_tk = tk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; frame_end = 1'b0;
    #1;
    chk("rst_out_count", {27'd0, out_count}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
`ifdef RESULT_STATS_EN
    chk("rst_stat_windows", stat_windows, 0);
    m_win = 0; m_det = 0;
`endif
    q.delete(); ph = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic          pv, ppf, fe, rdy;
    logic [W-1:0]  pt;
    pv = 1'b0; ppf = 1'b0; pt = '0;
`ifdef RESULT_STATS_EN
    m_win = 0; m_det = 0;
`endif
    do_reset();

    // In-order streaming at (5,7,1), (6,7,1), (9,2,3)
    step(1, 1, {10'd5, 10'd7, 5'd1}, 0, 1);
    step(1, 1, {10'd6, 10'd7, 5'd1}, 0, 1);
    step(1, 1, {10'd9, 10'd2, 5'd3}, 0, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);

    // Ten failing windows are consumed but never buffered
    for (int i = 0; i < 10; i++) step(1, 0, W'(i * 37), 0, 1);

    // Fill to full, hold the 17th, then release it alongside one pop
    for (int i = 0; i < 16; i++) step(1, 1, W'(i + 100), 0, 0);
    step(1, 1, W'(999), 0, 0);
    chk("held_17th", {31'd0, in_taken}, 0);
    step(1, 1, W'(999), 0, 0);
    step(1, 1, W'(999), 0, 1);
    chk("take_17th_on_pop", {27'd0, out_count}, 16);
    for (int i = 0; i < 17; i++) step(0, 0, '0, 0, 1);

    // Four buffered, frame_end, drain: exactly one frame_done
    for (int i = 0; i < 4; i++) step(1, 1, W'(i + 200), 0, 0);
    step(0, 0, '0, 1, 0);
    fd_seen = 0;
    for (int i = 0; i < 8; i++) step(1, 1, W'(7), 0, 1);
    chk("frame_done_pulses", fd_seen, 1);

    // frame_end on an empty FIFO
    fd_seen = 0;
    step(0, 0, '0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);
    chk("empty_frame_done_pulses", fd_seen, 1);

    // Reset mid-frame with five buffered detections
    for (int i = 0; i < 5; i++) step(1, 1, W'(i + 300), 0, 0);
    step(0, 0, '0, 1, 0);
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1);
    chk("no_done_after_abort", fd_seen, 0);

    // Random traffic; a refused input stays stable until taken
    for (int i = 0; i < 600; i++) begin
      if (!pv || last_tk) begin
        pv  = ($urandom_range(0, 3) != 0);
        ppf = $urandom_range(0, 1) == 1;
        pt  = W'($urandom);
      end
      fe  = ($urandom_range(0, 40) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rnd_clr = ($urandom_range(0, 60) == 0);
      step(pv, ppf, pt, fe, rdy);
    end
    rnd_clr = 1'b0;
    step(0, 0, '0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
